// File: rtl/ysyx_2022040010_sram_resp_pkg.sv
// Shared memory-map defines for the ysyx_2022040010 pipeline: default base
// address, data word width, fetch width and a byte-lane mask helper.
package ysyx_2022040010_sram_resp_pkg;

  localparam logic [63:0] DEF_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam int          WORD_W        = 64;
  localparam int          FETCH_W       = 32;
  localparam int          LANES         = WORD_W / 8;

  function automatic logic [WORD_W-1:0] lane_mask(input logic [LANES-1:0] sel);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[8*i +: 8] = {8{sel[i]}};
    return m;
  endfunction

endpackage

// File: rtl/ysyx_2022040010_sram_array.sv
// Word-addressed storage: one byte-masked synchronous write port and two
// asynchronous read ports. Contents are deliberately not reset.
module ysyx_2022040010_sram_array
  import ysyx_2022040010_sram_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LANES-1:0]  wsel,
  input  logic [AW-1:0]     raddr_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [WORD_W-1:0] rdata_b
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] wmask;

  assign wmask = lane_mask(wsel);

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= (wdata & wmask) | (mem_q[waddr] & ~wmask);
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/ysyx_2022040010_sram_resp.sv
// Single-cycle SRAM responder serving an instruction fetch port and a data
// port, with write-first fetch bypass and a sticky first-fault capture.
module ysyx_2022040010_sram_resp
  import ysyx_2022040010_sram_resp_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               isram_e,
  input  logic [63:0]        isram_addr,
  output logic [FETCH_W-1:0] isram_rdata,
  input  logic               dsram_e,
  input  logic               dsram_we,
  input  logic [63:0]        dsram_addr,
  input  logic [WORD_W-1:0]  dsram_wdata,
  input  logic [LANES-1:0]   dsram_sel,
  output logic [WORD_W-1:0]  dsram_rdata,
  output logic               mem_err,
  output logic [63:0]        err_addr
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;

  logic [63:0]        i_off, d_off;
  logic               i_in, d_in, i_fault, d_fault, wr_en;
  logic [AW-1:0]      i_idx, d_idx;
  logic [WORD_W-1:0]  i_word, d_word, i_merged, wmask;
  logic [FETCH_W-1:0] isram_rdata_d, isram_rdata_q;
  logic [WORD_W-1:0]  dsram_rdata_d, dsram_rdata_q;
  logic               mem_err_d, mem_err_q;
  logic [63:0]        err_addr_d, err_addr_q;

  // Unsigned wrap makes addresses below the base land far above SPAN.
  assign i_off = isram_addr - BASE_ADDR;
  assign d_off = dsram_addr - BASE_ADDR;
  assign i_in  = i_off < SPAN;
  assign d_in  = d_off < SPAN;
  assign i_idx = i_off[AW+2:3];
  assign d_idx = d_off[AW+2:3];

  assign i_fault = isram_e & (~i_in | (isram_addr[1:0] != 2'b00));
  // An empty-lane write touches nothing, so it never counts as a fault.
  assign d_fault = dsram_e & ~d_in & ~(dsram_we & (dsram_sel == '0));
  assign wr_en   = dsram_e & dsram_we & d_in & (dsram_sel != '0);
  assign wmask   = lane_mask(dsram_sel);

  ysyx_2022040010_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .we     (wr_en),
    .waddr  (d_idx),
    .wdata  (dsram_wdata),
    .wsel   (dsram_sel),
    .raddr_a(i_idx),
    .rdata_a(i_word),
    .raddr_b(d_idx),
    .rdata_b(d_word)
  );

  always_comb begin
    i_merged = i_word;
    if (wr_en && (d_idx == i_idx)) i_merged = (dsram_wdata & wmask) | (i_word & ~wmask);

    isram_rdata_d = isram_rdata_q;
    if (isram_e) begin
      if (i_fault)            isram_rdata_d = '0;
      else if (isram_addr[2]) isram_rdata_d = i_merged[63:32];
      else                    isram_rdata_d = i_merged[31:0];
    end

    dsram_rdata_d = dsram_rdata_q;
    if (dsram_e && !dsram_we) dsram_rdata_d = d_fault ? '0 : d_word;

    mem_err_d  = mem_err_q;
    err_addr_d = err_addr_q;
    if (!mem_err_q && (i_fault || d_fault)) begin
      mem_err_d  = 1'b1;
      err_addr_d = d_fault ? dsram_addr : isram_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isram_rdata_q <= '0;
      dsram_rdata_q <= '0;
      mem_err_q     <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      isram_rdata_q <= isram_rdata_d;
      dsram_rdata_q <= dsram_rdata_d;
      mem_err_q     <= mem_err_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign isram_rdata = isram_rdata_q;
  assign dsram_rdata = dsram_rdata_q;
  assign mem_err     = mem_err_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_ysyx_2022040010_sram_resp.sv
// Directed bench for ysyx_2022040010_sram_resp: masked writes, fetch halves,
// write-first collision, faults, mid-operation reset and the array boundary.
module tb_ysyx_2022040010_sram_resp;

  logic        clk, rst;
  logic        isram_e;
  logic [63:0] isram_addr;
  logic [31:0] isram_rdata;
  logic        dsram_e, dsram_we;
  logic [63:0] dsram_addr, dsram_wdata;
  logic [7:0]  dsram_sel;
  logic [63:0] dsram_rdata;
  logic        mem_err;
  logic [63:0] err_addr;

  int vectors;
  int miscompares;

  ysyx_2022040010_sram_resp dut (
    .clk        (clk),
    .rst        (rst),
    .isram_e    (isram_e),
    .isram_addr (isram_addr),
    .isram_rdata(isram_rdata),
    .dsram_e    (dsram_e),
    .dsram_we   (dsram_we),
    .dsram_addr (dsram_addr),
    .dsram_wdata(dsram_wdata),
    .dsram_sel  (dsram_sel),
    .dsram_rdata(dsram_rdata),
    .mem_err    (mem_err),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every driver task starts and ends 1ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dwrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    dsram_e = 1'b1; dsram_we = 1'b1; dsram_addr = a; dsram_wdata = d; dsram_sel = s;
    tick();
    dsram_e = 1'b0; dsram_we = 1'b0; dsram_sel = 8'h00;
  endtask

  task automatic dread(input logic [63:0] a);
    dsram_e = 1'b1; dsram_we = 1'b0; dsram_addr = a;
    tick();
    dsram_e = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] a);
    isram_e = 1'b1; isram_addr = a;
    tick();
    isram_e = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    isram_e = 1'b0; isram_addr = '0;
    dsram_e = 1'b0; dsram_we = 1'b0; dsram_addr = '0; dsram_wdata = '0; dsram_sel = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("rst_isram", 64'(isram_rdata), 64'h0);
    chk("rst_dsram", dsram_rdata, 64'h0);
    chk("rst_err", 64'(mem_err), 64'h0);
    chk("rst_err_addr", err_addr, 64'h0);
    rst = 1'b1;
    tick();

    // masked write then read, plus hold on idle and write cycles
    dwrite(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    dwrite(64'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    dread(64'h8000_0010);
    chk("masked_read", dsram_rdata, 64'h1122_3344_CCCC_DDDD);
    tick();
    chk("dsram_hold_idle", dsram_rdata, 64'h1122_3344_CCCC_DDDD);
    dwrite(64'h8000_0030, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    chk("dsram_hold_write", dsram_rdata, 64'h1122_3344_CCCC_DDDD);
    dwrite(64'h8000_0010, 64'h9999_9999_9999_9999, 8'h00);
    dread(64'h8000_0010);
    chk("sel0_nowrite", dsram_rdata, 64'h1122_3344_CCCC_DDDD);
    chk("sel0_nofault", 64'(mem_err), 64'h0);

    // fetch halves, issued the cycle right after the write
    dwrite(64'h8000_0000, 64'h0000_0013_0010_0093, 8'hFF);
    fetch(64'h8000_0000);
    chk("fetch_lo", 64'(isram_rdata), 64'h0010_0093);
    fetch(64'h8000_0004);
    chk("fetch_hi", 64'(isram_rdata), 64'h0000_0013);
    tick();
    chk("isram_hold", 64'(isram_rdata), 64'h0000_0013);

    // same-cycle write and fetch of one word
    dsram_e = 1'b1; dsram_we = 1'b1; dsram_addr = 64'h8000_0020;
    dsram_wdata = 64'hDEAD_BEEF_0000_0000; dsram_sel = 8'hF0;
    isram_e = 1'b1; isram_addr = 64'h8000_0024;
    tick();
    dsram_e = 1'b0; dsram_we = 1'b0; dsram_sel = 8'h00; isram_e = 1'b0;
    chk("collision_bypass", 64'(isram_rdata), 64'hDEAD_BEEF);
    fetch(64'h8000_0024);
    chk("collision_landed", 64'(isram_rdata), 64'hDEAD_BEEF);
    chk("no_err_yet", 64'(mem_err), 64'h0);

    // faults
    dread(64'h7FFF_FFF8);
    chk("fault_rdata", dsram_rdata, 64'h0);
    chk("fault_flag", 64'(mem_err), 64'h1);
    chk("fault_addr", err_addr, 64'h7FFF_FFF8);
    fetch(64'h8000_0002);
    chk("misalign_rdata", 64'(isram_rdata), 64'h0);
    chk("misalign_addr_kept", err_addr, 64'h7FFF_FFF8);
    dwrite(64'h8000_8000, 64'h5555_5555_5555_5555, 8'hFF);
    dread(64'h8000_0000);
    chk("oob_write_dropped", dsram_rdata, 64'h0000_0013_0010_0093);
    chk("later_fault_kept", err_addr, 64'h7FFF_FFF8);

    // reset between edges during back-to-back reads
    dsram_e = 1'b1; dsram_we = 1'b0; dsram_addr = 64'h8000_0010;
    isram_e = 1'b1; isram_addr = 64'h8000_0000;
    tick();
    chk("pre_rst_dsram", dsram_rdata, 64'h1122_3344_CCCC_DDDD);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_isram", 64'(isram_rdata), 64'h0);
    chk("mid_rst_dsram", dsram_rdata, 64'h0);
    chk("mid_rst_err", 64'(mem_err), 64'h0);
    chk("mid_rst_err_addr", err_addr, 64'h0);
    #2 rst = 1'b1;
    tick();
    dsram_e = 1'b0; isram_e = 1'b0;
    chk("post_rst_dsram", dsram_rdata, 64'h1122_3344_CCCC_DDDD);
    chk("post_rst_isram", 64'(isram_rdata), 64'h0010_0093);

    // simultaneous fetch and data faults
    isram_e = 1'b1; isram_addr = 64'h8000_0001;
    dsram_e = 1'b1; dsram_we = 1'b0; dsram_addr = 64'h9000_0000;
    tick();
    isram_e = 1'b0; dsram_e = 1'b0;
    chk("dual_fault_flag", 64'(mem_err), 64'h1);
    chk("dual_fault_addr", err_addr, 64'h9000_0000);
    chk("dual_fault_isram", 64'(isram_rdata), 64'h0);

    // last word and the one past it
    pulse_reset();
    dwrite(64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF);
    dread(64'h8000_7FF8);
    chk("last_word", dsram_rdata, 64'h0123_4567_89AB_CDEF);
    chk("last_word_ok", 64'(mem_err), 64'h0);
    fetch(64'h8000_7FFC);
    chk("last_fetch", 64'(isram_rdata), 64'h0123_4567);
    dread(64'h8000_8000);
    chk("past_end_rdata", dsram_rdata, 64'h0);
    chk("past_end_flag", 64'(mem_err), 64'h1);
    chk("past_end_addr", err_addr, 64'h8000_8000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
